// File: rtl/anneal_flip_sequencer.sv
// Run-level controller for one annealing run: flush, warm-up fill of the energy FIFO,
// comparison-enabled run phase, then drain. Tracks iterations, stalls and best energy.
module anneal_flip_sequencer #(
    parameter int NUM_SPIN         = 256,
    parameter int SPIN_DEPTH       = 2,
    parameter int ENERGY_TOTAL_BIT = 32,
    parameter int ITER_W           = 16
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               en_i,
    input  logic                               start_i,
    input  logic                               abort_i,
    input  logic        [ITER_W-1:0]           cfg_iter_i,
    input  logic        [ITER_W-1:0]           cfg_stall_limit_i,
    input  logic                               energy_valid_i,
    output logic                               energy_ready_o,
    input  logic signed [ENERGY_TOTAL_BIT-1:0] energy_i,
    output logic                               energy_valid_o,
    input  logic                               energy_ready_i,
    input  logic                               spin_valid_i,
    input  logic                               spin_ready_i,
    input  logic                               spin_push_none_i,
    output logic                               flush_o,
    output logic                               en_comparison_o,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               early_stop_o,
    output logic                               aborted_o,
    output logic        [ITER_W-1:0]           iter_cnt_o,
    output logic        [ITER_W-1:0]           stall_cnt_o,
    output logic signed [ENERGY_TOTAL_BIT-1:0] best_energy_o,
    output logic                               best_valid_o,
    output logic        [2:0]                  state_o
);

    localparam int OW = $clog2(SPIN_DEPTH + 1) + 1;
    localparam int WW = $clog2(SPIN_DEPTH + 1);
    localparam logic signed [ENERGY_TOTAL_BIT-1:0] E_MAX = {1'b0, {(ENERGY_TOTAL_BIT-1){1'b1}}};

    if (NUM_SPIN < 1 || SPIN_DEPTH < 1) begin : g_bad_params
        $error("NUM_SPIN and SPIN_DEPTH must be positive");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FLUSH  = 3'd1,
        S_WARMUP = 3'd2,
        S_RUN    = 3'd3,
        S_DRAIN  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                        state;
    logic [ITER_W-1:0]             iter_lim, stall_lim, iter_cnt, stall_cnt;
    logic [OW-1:0]                 outstanding;
    logic [WW-1:0]                 warm_cnt;
    logic signed [ENERGY_TOTAL_BIT-1:0] best_energy;
    logic                          best_valid, early_stop, aborted, en_cmp;
    logic                          eh_d, eh_run_d;

    // Handshake rule: a transfer happens in a cycle where valid and ready are both high.
    // Energy valid/ready pass straight through (no latency) but only while en_i is high
    // and the run is in WARMUP or RUN; spin transfers are only observed, never gated.
    logic act, eh, sh, abort_take;
    assign act            = en_i & ((state == S_WARMUP) | (state == S_RUN));
    assign energy_valid_o = energy_valid_i & act;
    assign energy_ready_o = energy_ready_i & act;
    assign eh             = energy_valid_o & energy_ready_i;
    assign sh             = spin_valid_i & spin_ready_i;
    assign abort_take     = en_i & abort_i &
                            (state inside {S_FLUSH, S_WARMUP, S_RUN, S_DRAIN});

    logic [ITER_W:0]   iter_sum;
    logic [ITER_W-1:0] iter_inc, stall_inc;
    logic              iter_hit, stall_eval, stall_hit, warm_last;
    assign iter_sum   = {1'b0, iter_cnt} + {{ITER_W{1'b0}}, 1'b1};
    assign iter_inc   = (&iter_cnt) ? iter_cnt : iter_cnt + ITER_W'(1);
    assign stall_inc  = (&stall_cnt) ? stall_cnt : stall_cnt + ITER_W'(1);
    assign iter_hit   = eh & (iter_sum == {1'b0, iter_lim});
    // The push-none flag describes the energy accepted one cycle earlier.
    assign stall_eval = en_i & eh_run_d & ((state == S_RUN) | (state == S_DRAIN));
    assign stall_hit  = stall_eval & spin_push_none_i & (stall_lim != '0) &
                        (stall_inc == stall_lim);
    assign warm_last  = eh & (warm_cnt == WW'(SPIN_DEPTH - 1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            iter_lim    <= '0;
            stall_lim   <= '0;
            iter_cnt    <= '0;
            stall_cnt   <= '0;
            outstanding <= '0;
            warm_cnt    <= '0;
            best_energy <= E_MAX;
            best_valid  <= 1'b0;
            early_stop  <= 1'b0;
            aborted     <= 1'b0;
            en_cmp      <= 1'b0;
            eh_d        <= 1'b0;
            eh_run_d    <= 1'b0;
        end else if (en_i) begin
            eh_d     <= eh;
            eh_run_d <= eh & (state == S_RUN);

            if (state == S_FLUSH) begin
                outstanding <= '0;
            end else if (eh && !sh) begin
                outstanding <= outstanding + OW'(1);
            end else if (sh && !eh && outstanding != '0) begin
                outstanding <= outstanding - OW'(1);
            end

            if (eh && (!best_valid || energy_i < best_energy)) begin
                best_energy <= energy_i;
                best_valid  <= 1'b1;
            end
            if (eh && state == S_RUN) begin
                iter_cnt <= iter_inc;
            end
            if (stall_eval) begin
                stall_cnt <= spin_push_none_i ? stall_inc : '0;
            end
            if (stall_hit) begin
                early_stop <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        iter_lim    <= cfg_iter_i;
                        stall_lim   <= cfg_stall_limit_i;
                        iter_cnt    <= '0;
                        stall_cnt   <= '0;
                        best_valid  <= 1'b0;
                        best_energy <= E_MAX;
                        early_stop  <= 1'b0;
                        aborted     <= 1'b0;
                        en_cmp      <= 1'b0;
                        state       <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    warm_cnt <= '0;
                    state    <= S_WARMUP;
                end
                S_WARMUP: begin
                    if (eh) begin
                        warm_cnt <= warm_cnt + WW'(1);
                    end
                    if (warm_last) begin
                        en_cmp <= (iter_lim != '0);
                        state  <= (iter_lim == '0) ? S_DRAIN : S_RUN;
                    end
                end
                S_RUN: begin
                    if (stall_hit || iter_hit) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (outstanding == '0 && !eh_d) begin
                        state <= S_DONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (abort_take) begin
                aborted <= 1'b1;
                state   <= S_DONE;
            end
        end
    end

    assign flush_o         = (en_i & (state == S_FLUSH)) | abort_take;
    assign done_o          = en_i & (state == S_DONE);
    assign busy_o          = (state != S_IDLE);
    assign en_comparison_o = en_cmp;
    assign early_stop_o    = early_stop;
    assign aborted_o       = aborted;
    assign iter_cnt_o      = iter_cnt;
    assign stall_cnt_o     = stall_cnt;
    assign best_energy_o   = best_energy;
    assign best_valid_o    = best_valid;
    assign state_o         = state;

endmodule

// File: tb/tb_anneal_flip_sequencer.sv
// Directed bench for anneal_flip_sequencer: run sequencing, stall exit, gating, abort, reset.
module tb_anneal_flip_sequencer;

    localparam int EW = 32;
    localparam int IW = 16;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic signed [EW-1:0] E_MAX = 32'sh7FFF_FFFF;

    logic clk, rst, en, start, abort;
    logic [IW-1:0] cfg_iter, cfg_stall;
    logic e_valid_i, e_ready_o, e_valid_o, e_ready_i;
    logic signed [EW-1:0] energy;
    logic s_valid, s_ready, push_none;
    logic flush, en_cmp, busy, done, early, aborted, best_valid;
    logic [IW-1:0] iter_cnt, stall_cnt;
    logic signed [EW-1:0] best;
    logic [2:0] state;

    int checks = 0;
    int failures = 0;
    logic [EW-1:0] exp_q[$];

    anneal_flip_sequencer #(
        .NUM_SPIN(256), .SPIN_DEPTH(2), .ENERGY_TOTAL_BIT(EW), .ITER_W(IW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .en_i(en), .start_i(start), .abort_i(abort),
        .cfg_iter_i(cfg_iter), .cfg_stall_limit_i(cfg_stall),
        .energy_valid_i(e_valid_i), .energy_ready_o(e_ready_o), .energy_i(energy),
        .energy_valid_o(e_valid_o), .energy_ready_i(e_ready_i),
        .spin_valid_i(s_valid), .spin_ready_i(s_ready), .spin_push_none_i(push_none),
        .flush_o(flush), .en_comparison_o(en_cmp), .busy_o(busy), .done_o(done),
        .early_stop_o(early), .aborted_o(aborted), .iter_cnt_o(iter_cnt),
        .stall_cnt_o(stall_cnt), .best_energy_o(best), .best_valid_o(best_valid),
        .state_o(state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // driver tasks
    task automatic start_run(input logic [IW-1:0] it, input logic [IW-1:0] sl);
        cfg_iter  = it;
        cfg_stall = sl;
        start     = 1'b1;
        step();
        start = 1'b0;
        #1 check("flush_after_start", flush, 1'b1);
        check("busy_after_start", busy, 1'b1);
        step();
        check("flush_one_cycle", flush, 1'b0);
    endtask

    task automatic send(input logic signed [EW-1:0] e, input logic sv, input logic exp_cmp);
        energy    = e;
        e_valid_i = 1'b1;
        s_valid   = sv;
        #1 check("en_comparison", en_cmp, exp_cmp);
        check("energy_valid_o", e_valid_o, 1'b1);
        step();
        e_valid_i = 1'b0;
        s_valid   = 1'b0;
        if (exp_q.size() > 0) check("best_energy_sb", best, exp_q.pop_front());
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            step();
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < max) begin
            step();
            cyc++;
        end
        check(tag, done, 1'b1);
    endtask

    int cyc;

    initial begin
        rst = 1'b1; en = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_iter = '0; cfg_stall = '0;
        e_valid_i = 1'b0; e_ready_i = 1'b1; energy = '0;
        s_valid = 1'b0; s_ready = 1'b1; push_none = 1'b0;
        step(); step();
        check("rst_busy", busy, 1'b0);
        check("rst_flush", flush, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_iter", iter_cnt, 0);
        check("rst_stall", stall_cnt, 0);
        check("rst_best", best, E_MAX);
        check("rst_best_valid", best_valid, 1'b0);
        check("rst_en_cmp", en_cmp, 1'b0);
        check("rst_early_aborted", {early, aborted}, 2'b00);
        rst = 1'b0;
        step();

        // Run 1: iter=4, no stall limit, energies 10,8,9,7,12,3
        start_run(16'd4, 16'd0);
        exp_q.push_back(32'd10); exp_q.push_back(32'd8); exp_q.push_back(32'd8);
        exp_q.push_back(32'd7);  exp_q.push_back(32'd7); exp_q.push_back(32'd3);
        send(10, 1'b0, 1'b0);
        send(8, 1'b0, 1'b0);
        check("r1_state_run", state, ST_RUN);
        send(9, 1'b1, 1'b1);
        send(7, 1'b1, 1'b1);
        send(12, 1'b1, 1'b1);
        check("r1_iter_3", iter_cnt, 3);
        send(3, 1'b1, 1'b1);
        check("r1_iter_4", iter_cnt, 4);
        check("r1_state_drain", state, ST_DRAIN);
        drain(2);
        check("r1_no_done_yet", done, 1'b0);
        wait_done("r1_done", 20, cyc);
        check("r1_done_latency", cyc, 1);
        step();
        check("r1_done_pulse", done, 1'b0);
        check("r1_idle", busy, 1'b0);
        check("r1_best_held", best, 32'sd3);
        check("r1_flags", {best_valid, early, aborted}, 3'b100);

        // Run 2: stall limit 2, two consecutive push-none results
        start_run(16'd10, 16'd2);
        send(100, 1'b0, 1'b0);
        send(90, 1'b0, 1'b0);
        send(95, 1'b1, 1'b1);
        push_none = 1'b1;
        step();
        check("r2_stall_1", stall_cnt, 1);
        send(96, 1'b1, 1'b1);
        step();
        push_none = 1'b0;
        check("r2_early_stop", early, 1'b1);
        check("r2_stall_2", stall_cnt, 2);
        check("r2_iter_2", iter_cnt, 2);
        check("r2_state_drain", state, ST_DRAIN);
        check("r2_cmp_held", en_cmp, 1'b1);
        e_valid_i = 1'b1;
        #1 check("r2_drain_gate_valid", e_valid_o, 1'b0);
        check("r2_drain_gate_ready", e_ready_o, 1'b0);
        e_valid_i = 1'b0;
        drain(2);
        wait_done("r2_done", 20, cyc);
        step();
        check("r2_early_after_done", early, 1'b1);

        // Run 3: push-none 1,0,1 with limit 2 never trips
        start_run(16'd3, 16'd2);
        check("r3_early_cleared", early, 1'b0);
        send(5, 1'b0, 1'b0);
        send(6, 1'b0, 1'b0);
        send(4, 1'b1, 1'b1);
        push_none = 1'b1;
        step();
        check("r3_stall_a", stall_cnt, 1);
        send(4, 1'b1, 1'b1);
        push_none = 1'b0;
        step();
        check("r3_stall_b", stall_cnt, 0);
        send(4, 1'b1, 1'b1);
        push_none = 1'b1;
        step();
        push_none = 1'b0;
        check("r3_stall_c", stall_cnt, 1);
        check("r3_no_early", early, 1'b0);
        drain(2);
        wait_done("r3_done", 20, cyc);
        step();
        check("r3_no_early_end", early, 1'b0);

        // Run 4: ready low freezes iterations; en low gates and holds
        start_run(16'd3, 16'd0);
        send(50, 1'b0, 1'b0);
        send(40, 1'b0, 1'b0);
        send(45, 1'b1, 1'b1);
        e_ready_i = 1'b0;
        e_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 check("r4_ready_gated", e_ready_o, 1'b0);
            step();
        end
        check("r4_iter_frozen", iter_cnt, 1);
        e_ready_i = 1'b1;
        en = 1'b0;
        #1 check("r4_en_valid", e_valid_o, 1'b0);
        check("r4_en_ready", e_ready_o, 1'b0);
        step(); step(); step();
        check("r4_en_hold_state", state, ST_RUN);
        check("r4_en_hold_iter", iter_cnt, 1);
        en = 1'b1;
        e_valid_i = 1'b0;
        send(44, 1'b1, 1'b1);
        send(43, 1'b1, 1'b1);
        check("r4_iter_3", iter_cnt, 3);
        drain(2);
        wait_done("r4_done", 20, cyc);
        step();

        // Run 5a: abort during warm-up with one energy outstanding
        start_run(16'd5, 16'd0);
        send(7, 1'b0, 1'b0);
        abort = 1'b1;
        #1 check("r5_abort_flush", flush, 1'b1);
        step();
        abort = 1'b0;
        check("r5_abort_done", done, 1'b1);
        check("r5_aborted", aborted, 1'b1);
        step();
        check("r5_abort_idle", busy, 1'b0);

        // Run 5b: start during RUN is ignored
        start_run(16'd3, 16'd0);
        check("r5_aborted_cleared", aborted, 1'b0);
        send(1, 1'b1, 1'b0);
        send(2, 1'b1, 1'b0);
        send(3, 1'b1, 1'b1);
        cfg_iter = 16'd1;
        start = 1'b1;
        #1 check("r5_start_no_flush", flush, 1'b0);
        step();
        start = 1'b0;
        check("r5_start_ignored", state, ST_RUN);
        send(4, 1'b1, 1'b1);
        check("r5_iter_2_run", state, ST_RUN);
        send(5, 1'b1, 1'b1);
        check("r5_iter_3", iter_cnt, 3);
        wait_done("r5_done", 20, cyc);
        step();

        // Run 6a: zero iterations -> warm-up then straight to drain
        start_run(16'd0, 16'd0);
        send(9, 1'b1, 1'b0);
        send(8, 1'b1, 1'b0);
        check("r6_drain", state, ST_DRAIN);
        check("r6_cmp_off", en_cmp, 1'b0);
        wait_done("r6_done", 20, cyc);
        check("r6_iter_0", iter_cnt, 0);
        check("r6_best", best, 32'sd8);
        step();

        // Run 6b: asynchronous reset mid-RUN
        start_run(16'd5, 16'd0);
        send(20, 1'b1, 1'b0);
        send(30, 1'b1, 1'b0);
        send(-5, 1'b1, 1'b1);
        check("r6_best_neg", best, -32'sd5);
        check("r6_iter_1", iter_cnt, 1);
        #2 rst = 1'b1;
        #1 check("arst_busy", busy, 1'b0);
        check("arst_iter", iter_cnt, 0);
        check("arst_best", best, E_MAX);
        check("arst_best_valid", best_valid, 1'b0);
        check("arst_en_cmp", en_cmp, 1'b0);
        check("arst_flush", flush, 1'b0);
        step();
        rst = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
